save_chunk_port: RTL and testbench

Endpoint for one save-state chunk. Sits directly downstream of the save-state memory streamer, on its chunk query/stream bus. Answers descriptor queries for its chunk index and moves elements between the stream and one core-side memory through a req/ack port. One instance per chunk; the top level ORs the `data_ack` and `read_data` outputs of all instances.

---
 rtl/save_chunk_port_if.sv | 38 +++
 rtl/save_chunk_port.sv | 129 ++++++++++++
 tb/tb_save_chunk_port.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/save_chunk_port_if.sv
// Chunk query/stream bus plus the core-side memory req/ack port of one save-state chunk endpoint.
// The master is the streamer/memory side; the slave is save_chunk_port.
interface save_chunk_port_if #(
   parameter int ADDR_W = 16
);
   // Handshakes:
   //   stream: the master holds query_req/write_req/read_req until data_ack, a one-cycle strobe,
   //           then drops them before issuing the next request.
   //   memory: mem_req is held with mem_we/mem_addr/mem_wdata/mem_be stable until a one-cycle
   //           mem_ack, which also qualifies mem_rdata.
   logic              query_req;
   logic [7:0]        chunk_select;
   logic [31:0]       chunk_address;
   logic              write_req;
   logic [63:0]       write_data;
   logic              read_req;
   logic [63:0]       read_data;
   logic              data_ack;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic [7:0]        mem_be;
   logic [63:0]       mem_rdata;
   logic              mem_ack;

   modport master (
      output query_req, chunk_select, chunk_address, write_req, write_data, read_req,
             mem_rdata, mem_ack,
      input  read_data, data_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport slave (
      input  query_req, chunk_select, chunk_address, write_req, write_data, read_req,
             mem_rdata, mem_ack,
      output read_data, data_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/save_chunk_port.sv
// Save-state chunk endpoint: answers descriptor queries and moves elements to/from core memory.
// Optional build macro SAVE_CHUNK_CHECK_EN: restore queries are acked only on a matching descriptor.
module save_chunk_port #(
   parameter int CHUNK_ID = 0,
   parameter int SIZE     = 1024,
   parameter int WIDTH    = 1,
   parameter int ADDR_W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   save_chunk_port_if.slave    bus,
   output logic [2:0]          fsm_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      QACK    = 3'd1,
      MEM     = 3'd2,
      ACK     = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [63:0] DESC = {30'b0, 2'(WIDTH), 32'(SIZE)};

   localparam logic [63:0] ELEM_MASK = (WIDTH == 0) ? 64'h0000_0000_0000_00FF :
                                       (WIDTH == 1) ? 64'h0000_0000_0000_FFFF :
                                       (WIDTH == 2) ? 64'h0000_0000_FFFF_FFFF :
                                                      64'hFFFF_FFFF_FFFF_FFFF;

   localparam logic [7:0] ELEM_BE = (WIDTH == 0) ? 8'h01 :
                                    (WIDTH == 1) ? 8'h03 :
                                    (WIDTH == 2) ? 8'h0F : 8'hFF;

   state_t            state_q, state_d;
   logic [63:0]       data_q, data_d;
   logic              load_data, load_mem;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [63:0]       wdata_q;
   logic              sel, out_of_range, desc_ok, any_req;
   logic              unused_bits;

   assign sel          = (bus.chunk_select[2:0] == 3'(CHUNK_ID));
   assign out_of_range = (bus.chunk_address >= 32'(SIZE));
   assign any_req      = bus.write_req | bus.read_req | bus.query_req;
   assign unused_bits  = &{1'b0, bus.chunk_select[7:3]};

`ifdef SAVE_CHUNK_CHECK_EN
   assign desc_ok = (bus.write_data[33:0] == DESC[33:0]);
`else
   assign desc_ok = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      data_d    = '0;
      load_data = 1'b0;
      load_mem  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sel) begin
               if (bus.query_req) begin
                  if (bus.read_req) begin
                     state_d   = QACK;
                     data_d    = DESC;
                     load_data = 1'b1;
                  end else if (bus.write_req) begin
                     // A rejected restore query gets no ack so the streamer times out and skips us.
                     if (desc_ok) begin
                        state_d   = QACK;
                        load_data = 1'b1;
                     end else begin
                        state_d = RELEASE;
                     end
                  end
               end else if (bus.write_req | bus.read_req) begin
                  if (out_of_range) begin
                     state_d   = ACK;
                     load_data = 1'b1;
                  end else begin
                     state_d  = MEM;
                     load_mem = 1'b1;
                  end
               end
            end
         end
         QACK:    state_d = RELEASE;
         MEM: begin
            if (bus.mem_ack) begin
               state_d   = ACK;
               data_d    = bus.mem_rdata & ELEM_MASK;
               load_data = 1'b1;
            end
         end
         ACK:     state_d = RELEASE;
         RELEASE: if (!any_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_data) data_q <= data_d;
         if (load_mem) begin
            addr_q  <= bus.chunk_address[ADDR_W-1:0];
            we_q    <= bus.write_req;
            wdata_q <= bus.write_data & ELEM_MASK;
         end
      end
   end

   // Outputs are ORed across instances at the top, so read_data is gated to the ack cycle.
   assign bus.data_ack  = (state_q == QACK) || (state_q == ACK);
   assign bus.read_data = bus.data_ack ? data_q : 64'h0;
   assign bus.mem_req   = (state_q == MEM);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = bus.mem_req ? ELEM_BE : 8'h00;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_save_chunk_port.sv
// Directed bench for save_chunk_port: two instances (16-bit chunk 2, 8-bit chunk 4) on one stream.
module tb_save_chunk_port;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_MEM     = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd4;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] state_a, state_b;
   int         checks = 0;
   int         errors = 0;
   int         hits;

   always #5 clk = ~clk;

   save_chunk_port_if #(.ADDR_W(16)) bus_a ();
   save_chunk_port_if #(.ADDR_W(16)) bus_b ();

   assign bus_b.query_req     = bus_a.query_req;
   assign bus_b.chunk_select  = bus_a.chunk_select;
   assign bus_b.chunk_address = bus_a.chunk_address;
   assign bus_b.write_req     = bus_a.write_req;
   assign bus_b.write_data    = bus_a.write_data;
   assign bus_b.read_req      = bus_a.read_req;
   assign bus_b.mem_rdata     = bus_a.mem_rdata;
   assign bus_b.mem_ack       = bus_a.mem_ack;

   save_chunk_port #(.CHUNK_ID(2), .SIZE(1024), .WIDTH(1), .ADDR_W(16)) u_a (
      .clk(clk), .reset(reset), .bus(bus_a), .fsm_state(state_a)
   );

   save_chunk_port #(.CHUNK_ID(4), .SIZE(16), .WIDTH(0), .ADDR_W(16)) u_b (
      .clk(clk), .reset(reset), .bus(bus_b), .fsm_state(state_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drop_reqs();
      bus_a.query_req = 1'b0;
      bus_a.write_req = 1'b0;
      bus_a.read_req  = 1'b0;
      bus_a.mem_ack   = 1'b0;
      bus_a.mem_rdata = 64'h0;
   endtask

   initial begin
      reset = 1'b1;
      drop_reqs();
      bus_a.chunk_select  = 8'd0;
      bus_a.chunk_address = 32'd0;
      bus_a.write_data    = 64'h0;
      tick();
      tick();
      check("reset_ack", {63'b0, bus_a.data_ack | bus_b.data_ack}, 64'd0);
      check("reset_mem_req", {63'b0, bus_a.mem_req | bus_b.mem_req}, 64'd0);
      check("reset_read_data", bus_a.read_data | bus_b.read_data, 64'd0);
      check("reset_mem_be", {56'b0, bus_a.mem_be}, 64'd0);
      check("reset_state", {61'b0, state_a}, {61'b0, S_IDLE});
      reset = 1'b0;
      tick();

      // Save query on chunk 2
      bus_a.chunk_select = 8'd2;
      bus_a.query_req    = 1'b1;
      bus_a.read_req     = 1'b1;
      tick();
      check("sq_ack", {63'b0, bus_a.data_ack}, 64'd1);
      check("sq_desc", bus_a.read_data, 64'h1_0000_0400);
      check("sq_other_ack", {63'b0, bus_b.data_ack}, 64'd0);
      tick();
      check("sq_ack_drop", {63'b0, bus_a.data_ack}, 64'd0);
      check("sq_rdata_zero", bus_a.read_data, 64'd0);
      tick();
      check("sq_held_no_reack", {63'b0, bus_a.data_ack}, 64'd0);
      drop_reqs();
      tick();
      check("sq_back_idle", {61'b0, state_a}, {61'b0, S_IDLE});

      // Save element, memory acks four cycles after the request
      bus_a.read_req      = 1'b1;
      bus_a.chunk_address = 32'd5;
      tick();
      check("se_mem_req", {63'b0, bus_a.mem_req}, 64'd1);
      check("se_mem_addr", {48'b0, bus_a.mem_addr}, 64'd5);
      check("se_mem_we", {63'b0, bus_a.mem_we}, 64'd0);
      check("se_mem_be", {56'b0, bus_a.mem_be}, 64'h03);
      tick();
      tick();
      tick();
      check("se_req_held", {63'b0, bus_a.mem_req}, 64'd1);
      check("se_no_early_ack", {63'b0, bus_a.data_ack}, 64'd0);
      bus_a.mem_ack   = 1'b1;
      bus_a.mem_rdata = 64'hFFFF_1234;
      tick();
      drop_reqs();
      check("se_ack", {63'b0, bus_a.data_ack}, 64'd1);
      check("se_rdata", bus_a.read_data, 64'h1234);
      check("se_req_dropped", {63'b0, bus_a.mem_req}, 64'd0);
      tick();
      check("se_single_ack", {63'b0, bus_a.data_ack}, 64'd0);
      tick();

      // Restore element on the 8-bit chunk
      bus_a.chunk_select  = 8'd4;
      bus_a.write_req     = 1'b1;
      bus_a.write_data    = 64'hAB_CD;
      bus_a.chunk_address = 32'd7;
      tick();
      check("re_mem_req", {63'b0, bus_b.mem_req}, 64'd1);
      check("re_mem_we", {63'b0, bus_b.mem_we}, 64'd1);
      check("re_mem_wdata", bus_b.mem_wdata, 64'hCD);
      check("re_mem_be", {56'b0, bus_b.mem_be}, 64'h01);
      check("re_mem_addr", {48'b0, bus_b.mem_addr}, 64'd7);
      check("re_unsel_idle", {63'b0, bus_a.mem_req}, 64'd0);
      bus_a.mem_ack = 1'b1;
      tick();
      drop_reqs();
      check("re_ack", {63'b0, bus_b.data_ack}, 64'd1);
      tick();
      tick();

      // Restore query with a mismatching descriptor, held for the streamer's timeout
      bus_a.query_req  = 1'b1;
      bus_a.write_req  = 1'b1;
      bus_a.write_data = 64'h3_0000_0010;
      hits = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (bus_b.data_ack) hits++;
      end
`ifdef SAVE_CHUNK_CHECK_EN
      check("rq_bad_acks", 64'(hits), 64'd0);
`else
      check("rq_bad_acks", 64'(hits), 64'd1);
`endif
      check("rq_bad_release", {61'b0, state_b}, {61'b0, S_RELEASE});
      drop_reqs();
      tick();
      check("rq_bad_idle", {61'b0, state_b}, {61'b0, S_IDLE});

      // Restore query with the matching descriptor {WIDTH=0, SIZE=16}
      bus_a.query_req  = 1'b1;
      bus_a.write_req  = 1'b1;
      bus_a.write_data = 64'h0_0000_0010;
      tick();
      check("rq_good_ack", {63'b0, bus_b.data_ack}, 64'd1);
      check("rq_good_rdata", bus_b.read_data, 64'd0);
      drop_reqs();
      tick();
      tick();

      // Out-of-range element on chunk 2
      bus_a.chunk_select  = 8'd2;
      bus_a.read_req      = 1'b1;
      bus_a.chunk_address = 32'd1024;
      tick();
      check("oor_ack", {63'b0, bus_a.data_ack}, 64'd1);
      check("oor_rdata", bus_a.read_data, 64'd0);
      check("oor_no_mem", {63'b0, bus_a.mem_req}, 64'd0);
      drop_reqs();
      tick();
      tick();

      // Unselected chunk index: no activity from either instance
      bus_a.chunk_select  = 8'd3;
      bus_a.read_req      = 1'b1;
      bus_a.chunk_address = 32'd1;
      hits = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus_a.data_ack | bus_a.mem_req | bus_b.data_ack | bus_b.mem_req) hits++;
      end
      check("unsel_activity", 64'(hits), 64'd0);
      drop_reqs();
      tick();

      // Highest in-range element with both requests high: write wins
      bus_a.chunk_select  = 8'd2;
      bus_a.write_req     = 1'b1;
      bus_a.read_req      = 1'b1;
      bus_a.write_data    = 64'h1234_5678;
      bus_a.chunk_address = 32'd1023;
      tick();
      check("edge_mem_req", {63'b0, bus_a.mem_req}, 64'd1);
      check("edge_mem_we", {63'b0, bus_a.mem_we}, 64'd1);
      check("edge_mem_addr", {48'b0, bus_a.mem_addr}, 64'h3FF);
      check("edge_mem_wdata", bus_a.mem_wdata, 64'h5678);
      bus_a.mem_ack   = 1'b1;
      bus_a.mem_rdata = 64'hAAAA_5555;
      tick();
      drop_reqs();
      check("edge_rdata", bus_a.read_data, 64'h5555);
      tick();
      tick();

      // Reset while waiting on memory, then a normal transaction
      bus_a.read_req      = 1'b1;
      bus_a.chunk_address = 32'd9;
      tick();
      check("rst_pre_mem", {61'b0, state_a}, {61'b0, S_MEM});
      reset = 1'b1;
      tick();
      check("rst_mem_req", {63'b0, bus_a.mem_req}, 64'd0);
      check("rst_ack", {63'b0, bus_a.data_ack}, 64'd0);
      reset = 1'b0;
      drop_reqs();
      tick();
      bus_a.read_req = 1'b1;
      tick();
      check("rst_again_req", {63'b0, bus_a.mem_req}, 64'd1);
      bus_a.mem_ack   = 1'b1;
      bus_a.mem_rdata = 64'h1_0000_BEEF;
      tick();
      drop_reqs();
      check("rst_again_ack", {63'b0, bus_a.data_ack}, 64'd1);
      check("rst_again_rdata", bus_a.read_data, 64'hBEEF);
      tick();
      tick();
      check("final_idle", {61'b0, state_a}, {61'b0, S_IDLE});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
